// File: rtl/shared_bus_initiator.sv
// Shared-bus transaction initiator for the L2 cache.
// Takes one request at a time from the L2 controller, arbitrates for the bus,
// drives command/address, samples the snoop result, runs the data phase and
// returns a one-cycle response carrying the snoop result and any fetched line.
module shared_bus_initiator #(
  parameter int lineSize    = 512,
  parameter int addressSize = 32,
  parameter int snoopWait   = 2,
  parameter int arbTimeout  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // request side
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [1:0]             reqOp,
  input  logic [addressSize-1:0] reqAddr,
  input  logic [lineSize-1:0]    reqData,
  // bus side
  output logic                   busReq,
  input  logic                   busGrant,
  output logic [7:0]             busOp,
  output logic [addressSize-1:0] busAddr,
  output logic [lineSize-1:0]    busDataOut,
  output logic                   busDataOE,
  input  logic [lineSize-1:0]    busDataIn,
  input  logic [1:0]             snoopIn,
  // response side
  output logic                   rspValid,
  output logic [1:0]             rspSnoop,
  output logic [lineSize-1:0]    rspData,
  output logic                   rspTimeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CMD,
    S_SNOOP,
    S_DATA,
    S_RESP
  } state_e;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;

  // Counters run 0..N-1; the last value marks the final ARB / SNOOP cycle.
  localparam int ArbW = (arbTimeout > 1) ? $clog2(arbTimeout) : 1;
  localparam int SnpW = (snoopWait > 1) ? $clog2(snoopWait) : 1;
  localparam logic [ArbW-1:0] ArbLast = ArbW'(arbTimeout - 1);
  localparam logic [SnpW-1:0] SnpLast = SnpW'(snoopWait - 1);

  state_e                   state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic [addressSize-1:0]   addr_q, addr_d;
  logic [lineSize-1:0]      data_q, data_d;
  logic [ArbW-1:0]          arb_cnt_q, arb_cnt_d;
  logic [SnpW-1:0]          snp_cnt_q, snp_cnt_d;
  logic [1:0]               snoop_cap_q, snoop_cap_d;
  logic [1:0]               rsp_snoop_q, rsp_snoop_d;
  logic [lineSize-1:0]      rsp_data_q, rsp_data_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic                     ready_q, ready_d;

  logic [1:0]               snoop_filt;
  logic                     cmd_phase;
  logic                     write_phase;

  // Reserved snoop encoding is folded onto NOHIT before it is stored.
  assign snoop_filt = (snoopIn == 2'd3) ? 2'd0 : snoopIn;

  // Next-state, request latching, counters and response capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    arb_cnt_d     = arb_cnt_q;
    snp_cnt_d     = snp_cnt_q;
    snoop_cap_d   = snoop_cap_q;
    rsp_snoop_d   = rsp_snoop_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid && ready_q) begin
          op_d      = reqOp;
          addr_d    = reqAddr;
          data_d    = reqData;
          arb_cnt_d = '0;
          state_d   = S_ARB;
        end
      end
      S_ARB: begin
        // A grant seen in the same cycle the counter expires still wins.
        if (busGrant) begin
          state_d = S_CMD;
        end else if (arb_cnt_q == ArbLast) begin
          state_d       = S_RESP;
          rsp_timeout_d = 1'b1;
          rsp_snoop_d   = 2'd0;
          rsp_data_d    = '0;
        end else begin
          arb_cnt_d = arb_cnt_q + 1'b1;
        end
      end
      S_CMD: begin
        snp_cnt_d = '0;
        state_d   = S_SNOOP;
      end
      S_SNOOP: begin
        if (snp_cnt_q == SnpLast) begin
          snoop_cap_d = snoop_filt;
          if (op_q == OP_INV) begin
            // No data phase: the snoop result goes straight to the response.
            state_d       = S_RESP;
            rsp_timeout_d = 1'b0;
            rsp_snoop_d   = snoop_filt;
            rsp_data_d    = '0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          snp_cnt_d = snp_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        state_d       = S_RESP;
        rsp_timeout_d = 1'b0;
        rsp_snoop_d   = snoop_cap_q;
        rsp_data_d    = ((op_q == OP_READ) || (op_q == OP_RWIM)) ? busDataIn : '0;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // reqReady is a registered copy of "next state is IDLE", so it is low in reset
  // and rises on the first edge after release.
  assign ready_d = (state_d == S_IDLE);

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= 2'd0;
      addr_q        <= '0;
      data_q        <= '0;
      arb_cnt_q     <= '0;
      snp_cnt_q     <= '0;
      snoop_cap_q   <= 2'd0;
      rsp_snoop_q   <= 2'd0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      arb_cnt_q     <= arb_cnt_d;
      snp_cnt_q     <= snp_cnt_d;
      snoop_cap_q   <= snoop_cap_d;
      rsp_snoop_q   <= rsp_snoop_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      ready_q       <= ready_d;
    end
  end

  // Bus outputs are decoded from the state register and latched request only.
  always_comb begin
    cmd_phase   = (state_q == S_CMD) || (state_q == S_SNOOP) || (state_q == S_DATA);
    write_phase = (state_q == S_DATA) && (op_q == OP_WRITE);
    busReq      = (state_q == S_ARB) || cmd_phase;
    busOp       = cmd_phase ? (8'(op_q) + 8'd1) : 8'h00;
    busAddr     = cmd_phase ? addr_q : '0;
    busDataOE   = write_phase;
    busDataOut  = write_phase ? data_q : '0;
    rspValid    = (state_q == S_RESP);
  end

  assign reqReady   = ready_q;
  assign rspSnoop   = rsp_snoop_q;
  assign rspData    = rsp_data_q;
  assign rspTimeout = rsp_timeout_q;

endmodule

// File: tb/tb_shared_bus_initiator.sv
// Self-checking bench for shared_bus_initiator: directed scenarios plus
// randomized transactions compared against a cycle-arithmetic reference model.
module tb_shared_bus_initiator;
  localparam int LS   = 512;
  localparam int AS   = 32;
  localparam int SW   = 2;
  localparam int AT   = 15;
  localparam int MAXC = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [1:0]    reqOp = 2'd0;
  logic [AS-1:0] reqAddr = '0;
  logic [LS-1:0] reqData = '0;
  logic          busReq;
  logic          busGrant = 1'b0;
  logic [7:0]    busOp;
  logic [AS-1:0] busAddr;
  logic [LS-1:0] busDataOut;
  logic          busDataOE;
  logic [LS-1:0] busDataIn = '0;
  logic [1:0]    snoopIn = 2'd0;
  logic          rspValid;
  logic [1:0]    rspSnoop;
  logic [LS-1:0] rspData;
  logic          rspTimeout;

  shared_bus_initiator #(
    .lineSize(LS), .addressSize(AS), .snoopWait(SW), .arbTimeout(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqAddr(reqAddr), .reqData(reqData),
    .busReq(busReq), .busGrant(busGrant), .busOp(busOp), .busAddr(busAddr),
    .busDataOut(busDataOut), .busDataOE(busDataOE), .busDataIn(busDataIn), .snoopIn(snoopIn),
    .rspValid(rspValid), .rspSnoop(rspSnoop), .rspData(rspData), .rspTimeout(rspTimeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected per-cycle trace, index = cycle number after the handshake edge
  logic          exp_req   [MAXC];
  logic [7:0]    exp_op    [MAXC];
  logic          exp_oe    [MAXC];
  logic          exp_rspv  [MAXC];
  logic          exp_ready [MAXC];
  int            exp_resp, exp_snoop_cyc, exp_data_cyc;
  logic [1:0]    exp_snp;
  logic [LS-1:0] exp_rdata;
  logic          exp_to;

  // observations of the last transaction
  int            obs_resp, obs_first_op, obs_oe_cyc, obs_wait;
  logic [7:0]    obs_op_code;
  logic [1:0]    obs_snp;
  logic [LS-1:0] obs_rdata, obs_dout;
  logic          obs_to;
  time           obs_hs_time;

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] v;
    for (int i = 0; i < LS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: timeline derived from the protocol rules.
  // grant_at = first cycle busGrant is high (0 = never).
  task automatic model_txn(input logic [1:0] op, input int grant_at,
                           input logic [1:0] snoop, input logic [LS-1:0] rdata);
    int cmd, last;
    for (int c = 0; c < MAXC; c++) begin
      exp_req[c] = 0; exp_op[c] = 8'h00; exp_oe[c] = 0; exp_rspv[c] = 0; exp_ready[c] = 0;
    end
    exp_snoop_cyc = -1;
    exp_data_cyc  = -1;
    if (grant_at < 1 || grant_at > AT) begin
      for (int c = 1; c <= AT; c++) exp_req[c] = 1;
      exp_resp  = AT + 1;
      exp_snp   = 2'd0;
      exp_rdata = '0;
      exp_to    = 1'b1;
    end else begin
      cmd           = grant_at + 1;
      exp_snoop_cyc = cmd + SW;
      last          = exp_snoop_cyc;
      if (op != 2'd2) begin
        exp_data_cyc = last + 1;
        last         = last + 1;
      end
      for (int c = 1; c <= last; c++) exp_req[c] = 1;
      for (int c = cmd; c <= last; c++) exp_op[c] = 8'(op) + 8'd1;
      if (op == 2'd1) exp_oe[exp_data_cyc] = 1;
      exp_resp  = last + 1;
      exp_snp   = (snoop == 2'd3) ? 2'd0 : snoop;
      exp_rdata = (op == 2'd0 || op == 2'd3) ? rdata : '0;
      exp_to    = 1'b0;
    end
    exp_rspv[exp_resp]      = 1;
    exp_ready[exp_resp + 1] = 1;
  endtask

  // Runs one transaction, comparing every cycle against the model trace.
  // Returns at the negedge of the cycle after RESP so the next call can
  // handshake at the earliest opportunity.
  task automatic run_txn(input logic [1:0] op, input logic [AS-1:0] addr,
                         input logic [LS-1:0] wdata, input int grant_at,
                         input logic [1:0] snoop, input logic [LS-1:0] rdata,
                         input string name);
    model_txn(op, grant_at, snoop, rdata);
    obs_wait = 0;
    while (reqReady !== 1'b1 && obs_wait < 40) begin
      @(negedge clk);
      obs_wait++;
    end
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: reqReady=%b required 1", name, reqReady);
    end
    reqValid = 1'b1; reqOp = op; reqAddr = addr; reqData = wdata; busGrant = 1'b0;
    @(posedge clk);
    obs_hs_time = $time;
    #1;
    reqValid = 1'b0; reqOp = 2'($urandom); reqAddr = $urandom; reqData = rand_line();
    obs_resp = -1; obs_first_op = -1; obs_oe_cyc = -1; obs_op_code = 8'h00;
    obs_snp = 2'd0; obs_rdata = '0; obs_to = 1'b0; obs_dout = '0;
    for (int c = 1; c <= exp_resp + 1; c++) begin
      if (grant_at >= 1 && c == grant_at)     busGrant = 1'b1;
      else if (grant_at >= 1 && c > grant_at) busGrant = 1'($urandom);
      else                                    busGrant = 1'b0;
      snoopIn   = (c == exp_snoop_cyc) ? snoop : (snoop ^ 2'($urandom_range(1, 3)));
      busDataIn = (c == exp_data_cyc) ? rdata : ~rdata;
      @(negedge clk);
      checks += 5;
      if (busReq !== exp_req[c]) begin
        errors++; $display("FAIL %s busReq c%0d: got %b required %b", name, c, busReq, exp_req[c]);
      end
      if (busOp !== exp_op[c]) begin
        errors++; $display("FAIL %s busOp c%0d: got %h required %h", name, c, busOp, exp_op[c]);
      end
      if (busDataOE !== exp_oe[c]) begin
        errors++; $display("FAIL %s busDataOE c%0d: got %b required %b", name, c, busDataOE, exp_oe[c]);
      end
      if (rspValid !== exp_rspv[c]) begin
        errors++; $display("FAIL %s rspValid c%0d: got %b required %b", name, c, rspValid, exp_rspv[c]);
      end
      if (reqReady !== exp_ready[c]) begin
        errors++; $display("FAIL %s reqReady c%0d: got %b required %b", name, c, reqReady, exp_ready[c]);
      end
      if (exp_op[c] != 8'h00) begin
        checks++;
        if (busAddr !== addr) begin
          errors++; $display("FAIL %s busAddr c%0d: got %h required %h", name, c, busAddr, addr);
        end
      end
      if (exp_oe[c]) begin
        checks++;
        if (busDataOut !== wdata) begin
          errors++; $display("FAIL %s busDataOut c%0d: got %h required %h", name, c, busDataOut, wdata);
        end
      end
      if (c >= exp_resp) begin
        checks += 3;
        if (rspSnoop !== exp_snp) begin
          errors++; $display("FAIL %s rspSnoop c%0d: got %0d required %0d", name, c, rspSnoop, exp_snp);
        end
        if (rspTimeout !== exp_to) begin
          errors++; $display("FAIL %s rspTimeout c%0d: got %b required %b", name, c, rspTimeout, exp_to);
        end
        if (rspData !== exp_rdata) begin
          errors++; $display("FAIL %s rspData c%0d: got %h required %h", name, c, rspData, exp_rdata);
        end
      end
      if (rspValid === 1'b1 && obs_resp < 0) begin
        obs_resp = c; obs_snp = rspSnoop; obs_rdata = rspData; obs_to = rspTimeout;
      end
      if (busOp !== 8'h00 && obs_first_op < 0) begin
        obs_first_op = c; obs_op_code = busOp;
      end
      if (busDataOE === 1'b1 && obs_oe_cyc < 0) begin
        obs_oe_cyc = c; obs_dout = busDataOut;
      end
      if (c <= exp_resp) begin
        @(posedge clk);
        #1;
      end
    end
    $display("txn %s op=%0d addr=%h grant_at=%0d resp_cycle=%0d snoop=%0d timeout=%b",
             name, op, addr, grant_at, obs_resp, obs_snp, obs_to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if ({busReq, busOp, busDataOE, rspValid, rspSnoop, rspTimeout, reqReady} !== 15'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busReq=%b busOp=%h oe=%b rspValid=%b rspSnoop=%0d rspTimeout=%b reqReady=%b required all 0",
               busReq, busOp, busDataOE, rspValid, rspSnoop, rspTimeout, reqReady);
    end
    if (busAddr !== '0) begin
      errors++; $display("FAIL reset_busAddr: got %h required 0", busAddr);
    end
    if (busDataOut !== '0) begin
      errors++; $display("FAIL reset_busDataOut: got %h required 0", busDataOut);
    end
    if (rspData !== '0) begin
      errors++; $display("FAIL reset_rspData: got %h required 0", rspData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: reqReady=%b required 1", reqReady);
    end
  endtask

  task automatic test_read();
    logic [LS-1:0] a5;
    a5 = {64{8'hA5}};
    run_txn(2'd0, 32'h0000_1040, rand_line(), 1, 2'd0, a5, "read_nohit");
    checks += 4;
    if (obs_first_op != 2 || obs_op_code !== 8'h01) begin
      errors++; $display("FAIL read_cmd: first busOp cycle %0d code %h required cycle 2 code 01", obs_first_op, obs_op_code);
    end
    if (obs_resp != 6) begin
      errors++; $display("FAIL read_latency: rspValid cycle %0d required 6", obs_resp);
    end
    if (obs_snp !== 2'd0) begin
      errors++; $display("FAIL read_snoop: got %0d required 0", obs_snp);
    end
    if (obs_rdata !== a5) begin
      errors++; $display("FAIL read_data: got %h required %h", obs_rdata, a5);
    end
  endtask

  task automatic test_write();
    logic [LS-1:0] wd;
    wd = {16{32'h1234_5678}};
    run_txn(2'd1, 32'h0000_2000, wd, 1, 2'd0, rand_line(), "write");
    checks += 3;
    if (obs_oe_cyc != 5 || obs_dout !== wd) begin
      errors++; $display("FAIL write_oe: busDataOE cycle %0d data %h required cycle 5 data %h", obs_oe_cyc, obs_dout, wd);
    end
    if (obs_resp != 6) begin
      errors++; $display("FAIL write_latency: rspValid cycle %0d required 6", obs_resp);
    end
    if (obs_rdata !== '0) begin
      errors++; $display("FAIL write_rspData: got %h required 0", obs_rdata);
    end
  endtask

  task automatic test_invalidate();
    run_txn(2'd2, 32'h0000_3080, rand_line(), 1, 2'd1, rand_line(), "invalidate_hit");
    checks += 4;
    if (obs_first_op != 2 || obs_op_code !== 8'h03) begin
      errors++; $display("FAIL inv_cmd: first busOp cycle %0d code %h required cycle 2 code 03", obs_first_op, obs_op_code);
    end
    if (obs_resp != 5) begin
      errors++; $display("FAIL inv_latency: rspValid cycle %0d required 5", obs_resp);
    end
    if (obs_snp !== 2'd1) begin
      errors++; $display("FAIL inv_snoop: got %0d required 1", obs_snp);
    end
    if (obs_oe_cyc != -1) begin
      errors++; $display("FAIL inv_no_data: busDataOE seen in cycle %0d required never", obs_oe_cyc);
    end
  endtask

  task automatic test_delayed_grant();
    run_txn(2'd0, $urandom, rand_line(), 6, 2'd0, rand_line(), "grant_after_5");
    checks += 2;
    if (obs_first_op != 7) begin
      errors++; $display("FAIL delayed_grant_cmd: CMD cycle %0d required 7", obs_first_op);
    end
    if (obs_resp != 11) begin
      errors++; $display("FAIL delayed_grant_latency: rspValid cycle %0d required 11", obs_resp);
    end
    // grant in the very cycle the arbitration counter expires
    run_txn(2'd0, $urandom, rand_line(), AT, 2'd1, rand_line(), "grant_at_limit");
    checks += 2;
    if (obs_first_op != AT + 1) begin
      errors++; $display("FAIL grant_race_cmd: CMD cycle %0d required %0d", obs_first_op, AT + 1);
    end
    if (obs_to !== 1'b0) begin
      errors++; $display("FAIL grant_race_timeout: rspTimeout=%b required 0", obs_to);
    end
  endtask

  task automatic test_timeout();
    run_txn(2'd0, $urandom, rand_line(), 0, 2'd2, rand_line(), "timeout");
    checks += 3;
    if (obs_resp != 16) begin
      errors++; $display("FAIL timeout_cycle: rspValid cycle %0d required 16", obs_resp);
    end
    if (obs_to !== 1'b1) begin
      errors++; $display("FAIL timeout_flag: rspTimeout=%b required 1", obs_to);
    end
    if (obs_first_op != -1) begin
      errors++; $display("FAIL timeout_busop: busOp nonzero in cycle %0d required never", obs_first_op);
    end
  endtask

  task automatic test_rwim();
    logic [LS-1:0] rd;
    rd = rand_line();
    run_txn(2'd3, $urandom, rand_line(), 1, 2'd2, rd, "rwim_hitm");
    checks += 2;
    if (obs_snp !== 2'd2 || obs_op_code !== 8'h04) begin
      errors++; $display("FAIL rwim_hitm: rspSnoop %0d busOp %h required 2 and 04", obs_snp, obs_op_code);
    end
    if (obs_rdata !== rd) begin
      errors++; $display("FAIL rwim_data: got %h required %h", obs_rdata, rd);
    end
    run_txn(2'd3, $urandom, rand_line(), 1, 2'd3, rand_line(), "rwim_reserved");
    checks++;
    if (obs_snp !== 2'd0) begin
      errors++; $display("FAIL rwim_reserved: rspSnoop %0d required 0", obs_snp);
    end
  endtask

  task automatic test_reset_mid_snoop();
    int seen;
    while (reqReady !== 1'b1) @(negedge clk);
    reqValid = 1'b1; reqOp = 2'd0; reqAddr = 32'h0000_4000; reqData = rand_line(); busGrant = 1'b1;
    snoopIn = 2'd1; busDataIn = rand_line();
    @(posedge clk); #1;          // cycle 1 (ARB)
    reqValid = 1'b0;
    @(posedge clk); #1;          // cycle 2 (CMD)
    @(posedge clk); #1;          // cycle 3 (SNOOP)
    checks++;
    if (busReq !== 1'b1 || busOp !== 8'h01) begin
      errors++; $display("FAIL mid_snoop_active: busReq=%b busOp=%h required 1 and 01", busReq, busOp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busReq !== 1'b0 || busOp !== 8'h00 || rspValid !== 1'b0 || reqReady !== 1'b0) begin
      errors++;
      $display("FAIL mid_snoop_abort: busReq=%b busOp=%h rspValid=%b reqReady=%b required all 0",
               busReq, busOp, rspValid, reqReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rspValid === 1'b1) seen++;
    end
    checks += 2;
    if (seen != 0) begin
      errors++; $display("FAIL mid_snoop_no_rsp: rspValid seen %0d times required 0", seen);
    end
    if (reqReady !== 1'b1) begin
      errors++; $display("FAIL mid_snoop_ready: reqReady=%b required 1", reqReady);
    end
    run_txn(2'd0, 32'h0000_5040, rand_line(), 1, 2'd2, rand_line(), "read_after_reset");
  endtask

  task automatic test_back_to_back();
    time t_prev;
    run_txn(2'd0, $urandom, rand_line(), 1, 2'd0, rand_line(), "b2b_0");
    for (int i = 1; i < 3; i++) begin
      t_prev = obs_hs_time;
      run_txn(2'd0, $urandom, rand_line(), 1, 2'($urandom), rand_line(), "b2b");
      checks++;
      if ((obs_hs_time - t_prev) != 70) begin
        errors++; $display("FAIL b2b_spacing: %0d time units between handshakes required 70", obs_hs_time - t_prev);
      end
    end
  endtask

  task automatic test_random();
    int r, g;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      g = 0;
      else if (r == 1) g = $urandom_range(AT - 1, AT + 1);
      else             g = $urandom_range(1, 4);
      run_txn(2'($urandom), $urandom, rand_line(), g, 2'($urandom), rand_line(), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_invalidate();
    test_delayed_grant();
    test_timeout();
    test_rwim();
    test_reset_mid_snoop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
